dbg_bus_ctrl: RTL

DBG_BUS_CTRL -- requirements
Module: dbg_bus_ctrl

---
 rtl/dbg_bus_ctrl_pkg.sv | 28 ++
 rtl/dbg_timeout_cnt.sv | 38 +++
 rtl/dbg_bus_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dbg_bus_ctrl_pkg.sv
// Shared command opcodes, reply codes and controller state encoding for the
// UART debug bus controller.
package dbg_cmd_defs;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_HOLD  = 8'h06;
    localparam logic [7:0] OP_RUN   = 8'h07;

    localparam logic [7:0] REPLY_NOHOLD  = 8'h00;
    localparam logic [7:0] REPLY_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_BUS,
        ST_TX_START,
        ST_TX_WAIT
    } state_e;

    // States that collect operand bytes and are therefore guarded by the timeout.
    function automatic logic is_operand_state(input state_e s);
        return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Saturating idle-cycle counter; expired stays high once MAX_COUNT is reached
// until the next clear.
module dbg_timeout_cnt #(
    parameter int unsigned MAX_COUNT = 1048575
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_COUNT);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/dbg_bus_ctrl.sv
// UART-driven debug bus master: decodes WRITE/READ/HOLD/RUN byte commands,
// runs one bus transaction per command and returns a reply byte for READ.
//   state     | meaning
//   IDLE      | waiting for an opcode; HOLD/RUN applied here
//   ADDR_HI   | waiting for address high byte
//   ADDR_LO   | waiting for address low byte
//   DATA      | waiting for write data byte
//   BUS       | bus_req held until bus_ack or timeout
//   TX_START  | issue tx_start once the transmitter is free
//   TX_WAIT   | wait for the transmitter to finish the reply
module dbg_bus_ctrl
    import dbg_cmd_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        cpu_hold
);

    state_e      state_d, state_q;
    logic        we_d, we_q;
    logic [15:0] addr_d, addr_q;
    logic [7:0]  wdata_d, wdata_q;
    logic [7:0]  reply_d, reply_q;
    logic        hold_d, hold_q;
    logic        tx_seen_d, tx_seen_q;

    logic rx_accept;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    assign rx_accept = rx_valid && ((state_q == ST_IDLE) || is_operand_state(state_q));
    assign tmo_en    = (is_operand_state(state_q) && !rx_valid)
                     || ((state_q == ST_BUS) && !bus_ack);
    assign tmo_clr   = (state_d != state_q) || rx_accept;

    dbg_timeout_cnt #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        reply_d   = reply_q;
        hold_d    = hold_q;
        tx_seen_d = (state_q == ST_TX_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_WRITE: begin
                            we_d    = 1'b1;
                            state_d = ST_ADDR_HI;
                        end
                        OP_READ: begin
                            we_d    = 1'b0;
                            state_d = ST_ADDR_HI;
                        end
                        OP_HOLD: hold_d = 1'b1;
                        OP_RUN:  hold_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (rx_valid) begin
                    addr_d[15:8] = rx_data;
                    state_d      = ST_ADDR_LO;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    state_d     = we_q ? ST_DATA : ST_BUS;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
                    state_d = ST_BUS;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Without the bus grant the access is skipped, not stalled.
                if (!hold_q) begin
                    reply_d = REPLY_NOHOLD;
                    state_d = we_q ? ST_IDLE : ST_TX_START;
                end else if (bus_ack) begin
                    if (!we_q) begin
                        reply_d = bus_rdata;
                    end
                    state_d = we_q ? ST_IDLE : ST_TX_START;
                end else if (tmo_expired) begin
                    reply_d = REPLY_TIMEOUT;
                    state_d = we_q ? ST_IDLE : ST_TX_START;
                end
            end
            ST_TX_START: begin
                if (!tx_active) begin
                    state_d = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                // tx_active is ignored on the entry cycle so the UART has time to raise it.
                if (tx_seen_q && !tx_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            reply_q   <= '0;
            hold_q    <= 1'b0;
            tx_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            reply_q   <= reply_d;
            hold_q    <= hold_d;
            tx_seen_q <= tx_seen_d;
        end
    end

    assign bus_req   = rst && (state_q == ST_BUS) && hold_q;
    assign tx_start  = rst && (state_q == ST_TX_START) && !tx_active;
    assign tx_data   = reply_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign cpu_hold  = hold_q;

endmodule
